uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
UART transmit side for the Lab2 serial link; the counterpart to the receiver chain that counts 24 sample ticks to reach the middle of data bit 0.
- Accepts one byte per write handshake and serialises it onto TxD as a frame: start, 8 data LSB-first, parity, stop.
- Bit timing is derived from the shared oversampled baud tick Tx_sample_ENABLE, at 16 ticks per bit.
- Sits between the system-side write interface and the TxD pin; the baud controller is external.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
OVERSAMPLE, 16, Tx_sample_ENABLE pulses per transmitted bit
PARITY_EN, 1, 1 = parity bit inserted after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity (XOR of data), 1 = odd parity (inverted XOR)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
Tx_EN  input  1  transmitter enable; gates acceptance of new frames only
Tx_sample_ENABLE  input  1  one-clk-wide baud tick at 16x bit rate
Tx_WR  input  1  write strobe; one-clk pulse qualifies Tx_DATA
Tx_DATA  input  DATA_WIDTH  byte to send
TxD  output  1  serial line, idle high, registered
Tx_BUSY  output  1  high from the cycle after acceptance until the stop bit completes

Behaviour:
- Reset values: TxD=1, Tx_BUSY=0, state=IDLE, tick counter=0, bit index=0, shift register=0.
- Acceptance: in IDLE, Tx_WR && Tx_EN && !Tx_BUSY at a clk edge causes the following, all at that same edge:
  - Tx_DATA is latched.
  - Parity is computed from the latched value.
  - Tick counter is cleared.
  - State goes to START; TxD=0 and Tx_BUSY=1.
  - Latency from the Tx_WR edge to TxD falling is 1 clk.
- Tx_WR is ignored when Tx_BUSY=1 or Tx_EN=0. There is no queuing and no error flag.
- Tick counter (log2 OVERSAMPLE bits):
  - Increments on Tx_sample_ENABLE in every state except IDLE.
  - When it equals OVERSAMPLE-1 and Tx_sample_ENABLE=1, it wraps to 0 and the FSM advances one bit.
  - Each bit therefore lasts exactly 16 ticks.
  - Without Tx_sample_ENABLE the counter holds.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - START: TxD=0. Advance to DATA on bit end.
  - DATA: TxD=shift[0]. On each bit end, shift right and increment the bit index. After bit DATA_WIDTH-1 ends, go to PARITY, or to STOP if PARITY_EN=0.
  - PARITY: TxD=parity bit. Advance to STOP on bit end.
  - STOP: TxD=1. On bit end, go to IDLE and set Tx_BUSY=0 at the same edge.
- Back-to-back frames: a Tx_WR in the first IDLE cycle after STOP is accepted, so the minimum frame gap is 1 clk of idle-high.
- Tx_EN deasserted mid-frame: the in-flight frame completes normally; only new frames are blocked.
- Reset mid-frame: TxD returns to 1 and Tx_BUSY to 0 asynchronously. The partial frame is abandoned and the next frame starts clean.
- Tx_DATA changing after acceptance has no effect on the frame.
- Frame length: 11 bits = 176 ticks with PARITY_EN=1; 10 bits = 160 ticks otherwise.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit;
  - OVERSAMPLE and DATA_WIDTH defaults;
  - the parity-mode constants, shared with the receiver.
- One sub-module: tx_bit_timer. It is the OVERSAMPLE-count tick counter, with inputs clk, reset, run, Tx_sample_ENABLE and output bit_done (combinational: count==OVERSAMPLE-1 && Tx_sample_ENABLE).
- The FSM, shift register and parity live in uart_tx_framer.

Test Plan:
- Reset, then Tx_DATA=8'hA5, Tx_WR pulse, ticks every 4 clk:
  - TxD sequence per 16 ticks is 0,1,0,1,0,0,1,0,1,0,1 (parity=0, stop=1).
  - Tx_BUSY is high for 176 ticks, then low.
- Tx_DATA=8'h01, PARITY_ODD=1: parity bit=0. Tx_DATA=8'h00, PARITY_ODD=1: parity bit=1. With PARITY_EN=0, 8'h00 gives a 160-tick frame ending 0...0,1.
- Second Tx_WR with 8'hFF during the frame for 8'h3C: ignored. The line shows only 8'h3C's frame and no second frame follows.
- Tx_WR in the first IDLE cycle after STOP: the new start bit begins 1 clk after Tx_BUSY falls, and both frames decode correctly.
- Tx_EN=0 with Tx_WR: no frame and Tx_BUSY stays 0. Tx_EN dropped at data bit 3: the frame still completes all 11 bits.
- reset asserted during data bit 5 of 8'h55: TxD=1 and Tx_BUSY=0 immediately. After release, a new Tx_WR with 8'h81 produces a correct full frame.

Source files
------------

// File: rtl/uart_tx_framer_pkg.sv
// uart_tx_framer_pkg: state encoding and framing constants shared by the Lab2 UART transmitter and receiver
package uart_tx_framer_pkg;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam bit PARITY_MODE_EVEN = 1'b0;
    localparam bit PARITY_MODE_ODD = 1'b1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;
endpackage

// File: rtl/uart_tx_framer_timer.sv
// tx_bit_timer: counts baud ticks within one bit and flags the tick that ends the bit
module tx_bit_timer
    import uart_tx_framer_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic Tx_sample_ENABLE,
    output logic bit_done
);
    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    logic [CW-1:0] count_q, count_d;
    assign bit_done = (count_q == CW'(OVERSAMPLE - 1)) && Tx_sample_ENABLE;
    always_comb begin
        count_d = !run ? '0 : bit_done ? '0 : Tx_sample_ENABLE ? count_q + CW'(1) : count_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one byte per write as start, LSB-first data, optional parity and stop bits
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = PARITY_MODE_EVEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Tx_EN,
    input  logic                  Tx_sample_ENABLE,
    input  logic                  Tx_WR,
    input  logic [DATA_WIDTH-1:0] Tx_DATA,
    output logic                  TxD,
    output logic                  Tx_BUSY
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    tx_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic parity_q, parity_d, txd_q, txd_d, busy_q, busy_d, bit_done, last_data;
    tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk              (clk),
        .reset            (reset),
        .run              (state_q != IDLE),
        .Tx_sample_ENABLE (Tx_sample_ENABLE),
        .bit_done         (bit_done)
    );
    assign last_data = bit_idx_q == IW'(DATA_WIDTH - 1);
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        case (state_q)
            IDLE: if (Tx_WR && Tx_EN && !busy_q) begin
                state_d   = START;
                shift_d   = Tx_DATA;
                bit_idx_d = '0;
                parity_d  = (^Tx_DATA) ^ (PARITY_ODD == PARITY_MODE_ODD);
            end
            START: if (bit_done) state_d = DATA;
            DATA: if (bit_done) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + IW'(1);
                if (last_data) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP: if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // line level and busy follow the next state so both are registered with it
        txd_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? parity_d : 1'b1;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end
    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: scoreboard bench for even-parity, odd-parity and no-parity framer instances
module tb_uart_tx_framer;
    logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic wr_a = 1'b0, wr_b = 1'b0, en_a = 1'b1, en_b = 1'b1;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic [2:0] txd, busy;
    int checks = 0, fails = 0;
    logic [10:0] q0[$], q1[$], q2[$];
    logic [175:0] sbuf[3];
    int nt[3];
    logic pb[3];
    int tcnt = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .Tx_EN(en_a), .Tx_sample_ENABLE(tick), .Tx_WR(wr_a),
        .Tx_DATA(data_a), .TxD(txd[0]), .Tx_BUSY(busy[0]));
    uart_tx_framer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .Tx_EN(en_a), .Tx_sample_ENABLE(tick), .Tx_WR(wr_a),
        .Tx_DATA(data_a), .TxD(txd[1]), .Tx_BUSY(busy[1]));
    uart_tx_framer #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_nopar (
        .clk(clk), .reset(reset), .Tx_EN(en_b), .Tx_sample_ENABLE(tick), .Tx_WR(wr_b),
        .Tx_DATA(data_b), .TxD(txd[2]), .Tx_BUSY(busy[2]));

    // line bits in transmission order, bit 0 first
    function automatic logic [10:0] frame_of(input logic [7:0] d, input bit pe, input bit odd);
        return pe ? {1'b1, (^d) ^ odd, d, 1'b0} : {2'b01, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic end_frame(input int i);
        logic [10:0] e, a;
        int nb;
        bit ok;
        nb = (i == 2) ? 10 : 11;
        if (i == 0 && q0.size() > 0) e = q0.pop_front();
        else if (i == 1 && q1.size() > 0) e = q1.pop_front();
        else if (i == 2 && q2.size() > 0) e = q2.pop_front();
        else begin
            checks++;
            fails++;
            $display("FAIL unexpected_frame dut%0d at %0t: %0d ticks seen, no frame expected", i, $time, nt[i]);
            nt[i] = 0;
            return;
        end
        check($sformatf("frame_ticks dut%0d", i), nt[i], nb * 16);
        ok = 1'b1;
        a = '0;
        for (int k = 0; k < nb; k++) a[k] = sbuf[i][k*16+8];
        for (int k = 0; k < nb * 16 && k < nt[i] && k < 176; k++)
            if (sbuf[i][k] !== e[k/16]) ok = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL frame_bits dut%0d at %0t: got %h, expected %h", i, $time, a, e);
        end
        nt[i] = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            nt[i] = 0;
            pb[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset) begin
                    nt[i] = 0;
                    pb[i] = 1'b0;
                end else begin
                    if (!busy[i]) check("idle_high", txd[i], 1);
                    if (busy[i] && tick) begin
                        if (nt[i] < 176) sbuf[i][nt[i]] = txd[i];
                        nt[i]++;
                    end
                    if (pb[i] && !busy[i]) end_frame(i);
                    pb[i] = busy[i];
                end
            end
        end
    end

    task automatic wait_idle(input bit grp);
        int c = 0;
        while ((grp ? busy[2] : (busy[0] | busy[1])) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 3000) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout grp%0d at %0t: busy never dropped", grp, $time);
        end
    endtask

    task automatic send(input bit grp, input logic [7:0] d);
        wait_idle(grp);
        if (!grp) begin
            data_a = d;
            wr_a = 1'b1;
            q0.push_back(frame_of(d, 1'b1, 1'b0));
            q1.push_back(frame_of(d, 1'b1, 1'b1));
        end else begin
            data_b = d;
            wr_b = 1'b1;
            q2.push_back(frame_of(d, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        wr_a = 1'b0;
        wr_b = 1'b0;
        data_a = 8'($urandom);
        data_b = 8'($urandom);
        check("start_latency", grp ? {busy[2], txd[2]} : {busy[0], txd[0]}, 2'b10);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_txd", txd, 3'b111);
        check("reset_busy", busy, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1'b0, 8'hA5);
        send(1'b0, 8'h01);
        send(1'b0, 8'h00);
        send(1'b1, 8'h00);
        send(1'b0, 8'h3C);
        wait_ticks(40);
        @(posedge clk);
        #1;
        data_a = 8'hFF;
        wr_a = 1'b1;
        @(posedge clk);
        #1;
        wr_a = 1'b0;
        wait_idle(1'b0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("no_second_frame", busy[1:0], 2'b00);
        send(1'b0, 8'($urandom));
        send(1'b0, 8'($urandom));
        wait_idle(1'b0);
        en_a = 1'b0;
        data_a = 8'h77;
        wr_a = 1'b1;
        @(posedge clk);
        #1;
        wr_a = 1'b0;
        check("en_off_busy", busy[1:0], 2'b00);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("en_off_still_idle", busy[1:0], 2'b00);
        en_a = 1'b1;
        send(1'b0, 8'hC3);
        wait_ticks(72);
        en_a = 1'b0;
        wait_idle(1'b0);
        en_a = 1'b1;
        send(1'b0, 8'h55);
        wait_ticks(104);
        reset = 1'b1;
        #1;
        check("midreset_txd", txd[1:0], 2'b11);
        check("midreset_busy", busy[1:0], 2'b00);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send(1'b0, 8'h81);
        repeat (8) begin
            repeat ($urandom_range(0, 20)) begin
                @(posedge clk);
                #1;
            end
            send(1'b0, 8'($urandom));
        end
        repeat (5) send(1'b1, 8'($urandom));
        wait_idle(1'b0);
        wait_idle(1'b1);
        repeat (10) @(posedge clk);
        check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
